// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer
//   Sequences one convolution job (BlockCount*CellCount operand sets) through
//   the MacLatency-stage MAC datapath. Operand-set reads are issued at up to
//   one per cycle, per-stage pipeline enables follow each read down the
//   datapath, and each returning MAC result is summed into a job accumulator.
//   The final sum is offered over a valid/ready port.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   start       in   1-cycle pulse, begins a job (honoured in IDLE only)
//   abort       in   cancels the current job; wins over start
//   px_avail    in   pixel buffer holds at least one unread operand set
//   rd_en       out  pop one operand set this cycle
//   coeff_blk   out  coefficient block index for the current rd_en
//   coeff_cell  out  coefficient cell index for the current rd_en
//   stage_en    out  per-stage MAC pipeline register enables
//   mac_result  in   datapath output, valid when the last stage completes
//   acc_data    out  final job sum
//   acc_valid   out  acc_data valid, held until accepted
//   acc_ready   in   consumer accepts acc_data
//   busy        out  high in any state other than IDLE
//   done        out  1-cycle pulse on the acc_valid && acc_ready handshake

module mac_job_sequencer #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MacLatency = 4,
    parameter int unsigned BlockCount = 4,
    parameter int unsigned CellCount  = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic                                               abort,
    input  logic                                               px_avail,
    output logic                                               rd_en,
    output logic [((BlockCount > 1) ? $clog2(BlockCount) : 1)-1:0] coeff_blk,
    output logic [((CellCount > 1) ? $clog2(CellCount) : 1)-1:0]   coeff_cell,
    output logic [MacLatency-1:0]                              stage_en,
    input  logic [DataWidth-1:0]                               mac_result,
    output logic [DataWidth-1:0]                               acc_data,
    output logic                                               acc_valid,
    input  logic                                               acc_ready,
    output logic                                               busy,
    output logic                                               done
);

    localparam int unsigned JL = BlockCount * CellCount;
    localparam int unsigned BW = (BlockCount > 1) ? $clog2(BlockCount) : 1;
    localparam int unsigned CW = (CellCount > 1) ? $clog2(CellCount) : 1;
    localparam int unsigned IW = $clog2(JL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT
    } state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        blk_q, blk_d;
    logic [CW-1:0]        cell_q, cell_d;
    logic [IW-1:0]        issue_q, issue_d;
    logic [IW-1:0]        ret_q, ret_d;
    logic [MacLatency:0]  v_q, v_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic [DataWidth-1:0] acc_data_q, acc_data_d;
    logic                 acc_valid_q, acc_valid_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            cell_q      <= '0;
            issue_q     <= '0;
            ret_q       <= '0;
            v_q         <= '0;
            acc_q       <= '0;
            acc_data_q  <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            cell_q      <= cell_d;
            issue_q     <= issue_d;
            ret_q       <= ret_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
            acc_data_q  <= acc_data_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        cell_d      = cell_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        acc_d       = acc_q;
        acc_data_d  = acc_data_q;
        acc_valid_d = acc_valid_q;

        rd_en = (state_q == S_ISSUE) && px_avail;
        done  = acc_valid_q && acc_ready && !abort;

        // v[0] marks operands registered this cycle; v[MacLatency] marks the
        // cycle in which mac_result carries that operand set's product.
        v_d = {v_q[MacLatency-1:0], rd_en};

        if (v_q[MacLatency]) begin
            acc_d = acc_q + mac_result;
            ret_d = ret_q + 1'b1;
        end

        if (rd_en) begin
            issue_d = issue_q + 1'b1;
            if (blk_q == BW'(BlockCount - 1)) begin
                blk_d = '0;
                if (cell_q == CW'(CellCount - 1)) begin
                    cell_d = '0;
                end else begin
                    cell_d = cell_q + 1'b1;
                end
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    acc_d   = '0;
                    ret_d   = '0;
                    issue_d = '0;
                    blk_d   = '0;
                    cell_d  = '0;
                end
            end
            S_ISSUE: begin
                if (rd_en && (issue_q == IW'(JL - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the edge that absorbs the last result so the sum
                // is presented in the very next cycle.
                if (v_q[MacLatency] && (ret_q == IW'(JL - 1))) begin
                    state_d     = S_EMIT;
                    acc_valid_d = 1'b1;
                    acc_data_d  = acc_d;
                end
            end
            S_EMIT: begin
                if (acc_ready) begin
                    state_d     = S_IDLE;
                    acc_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards everything in flight, including a pending result.
        if (abort) begin
            state_d     = S_IDLE;
            v_d         = '0;
            issue_d     = '0;
            ret_d       = '0;
            blk_d       = '0;
            cell_d      = '0;
            acc_d       = '0;
            acc_valid_d = 1'b0;
        end
    end

    assign coeff_blk  = blk_q;
    assign coeff_cell = cell_q;
    assign stage_en   = v_q[MacLatency-1:0];
    assign acc_data   = acc_data_q;
    assign acc_valid  = acc_valid_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer (default parameters: JL=16,
// MacLatency=4). A small datapath model returns a value on mac_result
// exactly five cycles after each rd_en and drives a junk value otherwise.

module tb_mac_job_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, px_avail, acc_ready;
    logic [31:0] mac_result;
    logic        rd_en, acc_valid, busy, done;
    logic [1:0]  coeff_blk, coeff_cell;
    logic [3:0]  stage_en;
    logic [31:0] acc_data;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ret_k = 0;
    logic        mode_const = 1'b0;
    logic [31:0] const_val = '0;
    int          pend[$];

    mac_job_sequencer #(
        .DataWidth (32),
        .MacLatency(4),
        .BlockCount(4),
        .CellCount (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .px_avail  (px_avail),
        .rd_en     (rd_en),
        .coeff_blk (coeff_blk),
        .coeff_cell(coeff_cell),
        .stage_en  (stage_en),
        .mac_result(mac_result),
        .acc_data  (acc_data),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Datapath model: result for an rd_en in cycle c appears in cycle c+5.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                ret_k++;
                mac_result = mode_const ? const_val : 32'(ret_k);
            end else begin
                mac_result = 32'hBAD0_0001;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rd_en === 1'b1) pend.push_back(cyc + 5);
        end
    end

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; abort = 1'b0; px_avail = 1'b1; acc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({rd_en, busy, acc_valid, done, stage_en, coeff_blk, coeff_cell, acc_data} !== 44'h0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got rd=%b busy=%b av=%b done=%b st=%b blk=%0d cell=%0d data=%h, want all 0",
                         i, rd_en, busy, acc_valid, done, stage_en, coeff_blk, coeff_cell, acc_data);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({rd_en, busy, acc_valid, done, stage_en} !== 8'h0) begin
                n_err++;
                $display("FAIL reset_release_idle: got rd=%b busy=%b av=%b done=%b st=%b, want all 0",
                         rd_en, busy, acc_valid, done, stage_en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        logic [63:0] er;
        logic [3:0]  es;
        int          n_iss;
        er = '0;
        for (int i = 1; i <= 16; i++) er[i] = 1'b1;
        n_iss = 0; mode_const = 1'b0; ret_k = 0; px_avail = 1'b1; acc_ready = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            @(posedge clk); #1;
            start = (i == 0);
            @(negedge clk);
            for (int k = 0; k < 4; k++) es[k] = (i - 1 - k >= 0) ? er[i-1-k] : 1'b0;
            n_cmp++;
            if ({rd_en, busy, acc_valid, done} !== {er[i], (i >= 1 && i <= 22), (i == 22), (i == 22)}) begin
                n_err++;
                $display("FAIL basic_ctrl cyc%0d: got rd/busy/av/done=%b%b%b%b, want %b%b%b%b", i,
                         rd_en, busy, acc_valid, done, er[i], (i >= 1 && i <= 22), (i == 22), (i == 22));
            end
            n_cmp++;
            if (stage_en !== es) begin
                n_err++;
                $display("FAIL basic_stage_en cyc%0d: got %b, want %b", i, stage_en, es);
            end
            if (er[i]) begin
                n_cmp++;
                if ({coeff_cell, coeff_blk} !== 4'(n_iss)) begin
                    n_err++;
                    $display("FAIL basic_index cyc%0d: got cell=%0d blk=%0d, want cell=%0d blk=%0d",
                             i, coeff_cell, coeff_blk, n_iss / 4, n_iss % 4);
                end
                n_iss++;
            end
            if (i == 22) begin
                n_cmp++;
                if (acc_data !== 32'd136) begin
                    n_err++;
                    $display("FAIL basic_sum: got %0d, want 136", acc_data);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_stall();
        logic [63:0] er;
        int          n_iss;
        er = '0;
        for (int i = 1; i <= 5; i++) er[i] = 1'b1;
        for (int i = 9; i <= 19; i++) er[i] = 1'b1;
        n_iss = 0; mode_const = 1'b0; ret_k = 0; acc_ready = 1'b1;
        for (int i = 0; i <= 27; i++) begin
            @(posedge clk); #1;
            start    = (i == 0);
            px_avail = !(i >= 6 && i <= 8);
            @(negedge clk);
            n_cmp++;
            if ({rd_en, busy, acc_valid} !== {er[i], (i >= 1 && i <= 25), (i == 25)}) begin
                n_err++;
                $display("FAIL stall_ctrl cyc%0d: got rd/busy/av=%b%b%b, want %b%b%b", i,
                         rd_en, busy, acc_valid, er[i], (i >= 1 && i <= 25), (i == 25));
            end
            if (er[i]) begin
                n_cmp++;
                if ({coeff_cell, coeff_blk} !== 4'(n_iss)) begin
                    n_err++;
                    $display("FAIL stall_index cyc%0d: got cell=%0d blk=%0d, want cell=%0d blk=%0d",
                             i, coeff_cell, coeff_blk, n_iss / 4, n_iss % 4);
                end
                n_iss++;
            end
            if (i == 25) begin
                n_cmp++;
                if (acc_data !== 32'd136) begin
                    n_err++;
                    $display("FAIL stall_sum: got %0d, want 136", acc_data);
                end
            end
        end
        start = 1'b0; px_avail = 1'b1;
    endtask

    task automatic test_overflow();
        mode_const = 1'b1; const_val = 32'h2000_0000; ret_k = 0; px_avail = 1'b1; acc_ready = 1'b1;
        for (int i = 0; i <= 23; i++) begin
            @(posedge clk); #1;
            start = (i == 0);
            @(negedge clk);
            n_cmp++;
            if ({acc_valid, done} !== {(i == 22), (i == 22)}) begin
                n_err++;
                $display("FAIL overflow_valid cyc%0d: got av/done=%b%b, want %b%b",
                         i, acc_valid, done, (i == 22), (i == 22));
            end
            if (i == 22) begin
                n_cmp++;
                if (acc_data !== 32'h0000_0000) begin
                    n_err++;
                    $display("FAIL overflow_sum: got %h, want 00000000", acc_data);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_done;
        n_done = 0; mode_const = 1'b0; ret_k = 0; px_avail = 1'b1;
        for (int i = 0; i <= 34; i++) begin
            @(posedge clk); #1;
            start     = (i == 0 || i == 25);
            acc_ready = (i == 32);
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (i >= 22 && i <= 32) begin
                n_cmp++;
                if ({acc_valid, done, busy} !== {1'b1, (i == 32), 1'b1} || acc_data !== 32'd136) begin
                    n_err++;
                    $display("FAIL backpressure_hold cyc%0d: got av/done/busy=%b%b%b data=%0d, want 1%b1 data=136",
                             i, acc_valid, done, busy, acc_data, (i == 32));
                end
            end
            if (i >= 33) begin
                n_cmp++;
                if ({acc_valid, done, busy, rd_en} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL backpressure_idle cyc%0d: got av/done/busy/rd=%b%b%b%b, want 0000",
                             i, acc_valid, done, busy, rd_en);
                end
            end
        end
        n_cmp++;
        if (n_done != 1) begin
            n_err++;
            $display("FAIL backpressure_done_count: got %0d, want 1", n_done);
        end
        start = 1'b0; acc_ready = 1'b1;
    endtask

    task automatic test_abort();
        int n_av;
        n_av = 0; mode_const = 1'b1; const_val = 32'd1; ret_k = 0; px_avail = 1'b1; acc_ready = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk); #1;
            start = (i == 0);
            abort = (i == 19);
            @(negedge clk);
            if (acc_valid === 1'b1 || done === 1'b1) n_av++;
            if (i == 19) begin
                n_cmp++;
                if ({stage_en, busy} !== 5'b1100_1) begin
                    n_err++;
                    $display("FAIL abort_pre_stage cyc%0d: got st=%b busy=%b, want st=1100 busy=1", i, stage_en, busy);
                end
            end
            if (i == 20) begin
                n_cmp++;
                if ({stage_en, busy, rd_en} !== 6'b0) begin
                    n_err++;
                    $display("FAIL abort_flush: got st=%b busy=%b rd=%b, want all 0", stage_en, busy, rd_en);
                end
            end
        end
        abort = 1'b0;
        n_cmp++;
        if (n_av != 0) begin
            n_err++;
            $display("FAIL abort_no_result: got %0d valid/done cycles, want 0", n_av);
        end
        for (int j = 0; j <= 23; j++) begin
            @(posedge clk); #1;
            start = (j == 0);
            @(negedge clk);
            if (j == 21 || j == 22) begin
                n_cmp++;
                if ({acc_valid, done} !== {(j == 22), (j == 22)}) begin
                    n_err++;
                    $display("FAIL abort_rerun_valid cyc%0d: got av/done=%b%b, want %b%b",
                             j, acc_valid, done, (j == 22), (j == 22));
                end
            end
            if (j == 22) begin
                n_cmp++;
                if (acc_data !== 32'd16) begin
                    n_err++;
                    $display("FAIL abort_rerun_sum: got %0d, want 16", acc_data);
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; px_avail = 1'b0; acc_ready = 1'b0;
        mac_result = '0;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_backpressure();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
